// File: rtl/geofence_stim_if.sv
// Point/result channel between the stimulus engine and a geofence core.
interface geofence_stim_if;
    logic [9:0] X;
    logic [9:0] Y;
    logic       valid;
    logic       is_inside;

    modport master (output X, Y, input valid, is_inside);
    modport slave  (input X, Y, output valid, is_inside);
endinterface

// File: rtl/geofence_stim.sv
// Geofence pattern engine: per object, fetch golden word and seven points from a
// 1-cycle synchronous ROM, stream the points, then wait for and score the result.
module geofence_stim #(
    parameter int unsigned NUM_OBJ = 50,
    parameter int unsigned OBJ_W   = 7,
    parameter int unsigned TIMEOUT = 4095,
    parameter int unsigned TO_W    = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic [OBJ_W+2:0]    rom_addr,
    input  logic [19:0]         rom_data,
    geofence_stim_if.master     gf,
    output logic                busy,
    output logic                done,
    output logic [OBJ_W-1:0]    pass_cnt,
    output logic [OBJ_W-1:0]    fail_cnt,
    output logic                timeout_err,
    output logic                proto_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [OBJ_W-1:0] LAST_OBJ = OBJ_W'(NUM_OBJ - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    state_t              state;
    logic [OBJ_W-1:0]    obj;
    logic                fstep;
    logic [2:0]          pt;
    logic [TO_W-1:0]     wcnt;
    logic                gold;

    // Sequencer: ROM addressing runs two words ahead of the point being
    // loaded, so the address is advanced at the same posedge the previous
    // word's data is consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            obj         <= '0;
            fstep       <= 1'b0;
            pt          <= '0;
            wcnt        <= '0;
            gold        <= 1'b0;
            rom_addr    <= '0;
            gf.X        <= '0;
            gf.Y        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pass_cnt    <= '0;
                        fail_cnt    <= '0;
                        timeout_err <= 1'b0;
                        proto_err   <= 1'b0;
                        obj         <= '0;
                        rom_addr    <= {OBJ_W'(0), 3'd7};
                        fstep       <= 1'b0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        state       <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (gf.valid) proto_err <= 1'b1;
                    if (!fstep) begin
                        rom_addr <= {obj, 3'd0};
                        fstep    <= 1'b1;
                    end else begin
                        gold     <= rom_data[0];
                        rom_addr <= {obj, 3'd1};
                        pt       <= '0;
                        state    <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (gf.valid) proto_err <= 1'b1;
                    gf.X <= rom_data[19:10];
                    gf.Y <= rom_data[9:0];
                    if (pt <= 3'd4) rom_addr <= {obj, pt + 3'd2};
                    if (pt == 3'd6) begin
                        wcnt  <= '0;
                        state <= S_WAIT;
                    end else begin
                        pt <= pt + 3'd1;
                    end
                end

                S_WAIT: begin
                    if (gf.valid) begin
                        if (gf.is_inside == gold) pass_cnt <= pass_cnt + 1'b1;
                        else                      fail_cnt <= fail_cnt + 1'b1;
                        if (obj == LAST_OBJ) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            obj      <= obj + 1'b1;
                            rom_addr <= {obj + 1'b1, 3'd7};
                            fstep    <= 1'b0;
                            state    <= S_FETCH;
                        end
                    end else if (wcnt == TO_LAST) begin
                        fail_cnt    <= fail_cnt + 1'b1;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
